alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_INIT, default 1'b0, selecting which port holds round-robin priority after reset (0 = port 0).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports reqN_valid, input, 1, and reqN_ready, output, 1, the request handshake for N = 0,1.
REQ-005 SHALL have ports reqN_op, input, 4; reqN_a, input, 32; reqN_b, input, 32: the opcode and operands for N = 0,1.
REQ-006 SHALL have ports rspN_valid, output, 1, and rspN_ready, input, 1, the response handshake for N = 0,1.
REQ-007 SHALL have ports rspN_res, output, 32, and rspN_zero, output, 1, the registered result for N = 0,1.
REQ-008 SHALL have port gnt_cnt0 and gnt_cnt1, output, 16 each, the number of accepted requests per port.

Function
REQ-009 SHALL contain exactly one instance of the team ALU, shared by both ports, with a 4-bit operation code.
REQ-010 The opcode map SHALL be: 0 AND, 1 OR, 2 ADD, 3 XOR, 4 NOR, 5 SRL, 6 SUB, 7 SLTU, 9 SLT, 14 SLL, 15 SRA.
REQ-011 Shift amounts SHALL be B[3:0], and all other opcodes SHALL give res=0, zero=1; the block SHALL not alter ALU semantics.
REQ-012 Port N SHALL be eligible when reqN_valid=1 and (rspN_valid=0 or rspN_ready=1), i.e. its response slot is free or is draining this cycle.
REQ-013 For arbitration: only one port eligible -> that port is granted; both eligible -> the priority port is granted; none eligible -> no grant.
REQ-014 reqN_ready SHALL be 1 exactly when port N is granted this cycle, and SHALL be combinational from the valid, ready and pending inputs.
REQ-015 On a grant, the ALU operands and op SHALL be muxed from the granted port, and res/zero SHALL be captured into port N's response register at the next edge.
REQ-016 Latency SHALL be 1 cycle: rspN_valid=1 in the cycle after acceptance.
REQ-017 After each grant to port N, priority SHALL pass to the other port; priority SHALL be unchanged when there is no grant.
REQ-018 While rspN_valid=1 and rspN_ready=0, rspN_res and rspN_zero SHALL hold stable.
REQ-019 rspN_valid SHALL clear after an edge with rspN_ready=1, unless a new request for N is accepted in the same cycle; in that case it stays 1 with the new result, giving back-to-back throughput of 1 per cycle per port.
REQ-020 At most one request SHALL be accepted per cycle in total; the losing port's inputs SHALL be ignored, and its valid is expected to stay asserted.
REQ-021 Each port's response slot SHALL be independent: a stalled rsp0 SHALL not block port 1.
REQ-022 gnt_cntN SHALL increment by 1 on each accepted request for N and SHALL wrap from 16'hFFFF to 0.
REQ-023 The state machine per slot SHALL have two states: EMPTY -> FULL on accept; FULL -> EMPTY on ready without accept; FULL -> FULL on ready with accept, or on no ready.

Reset
REQ-024 When rstn=0, the block SHALL asynchronously force rspN_valid=0, rspN_res=0, rspN_zero=0, gnt_cntN=0 and priority=RR_INIT.
REQ-025 Responses pending at reset SHALL be discarded, and reqN_ready SHALL be 0 while rstn=0.
REQ-026 The first grant SHALL be possible on the first rising edge after rstn deasserts.

Verification
REQ-027 Scenario: port 0 only, op=2, A=5, B=7, rsp0_ready=1 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, res=12, zero=0; gnt_cnt0=1.
REQ-028 Scenario: both valid every cycle, RR_INIT=0, rsp ready=1 -> grants alternate 0,1,0,1; after 4 cycles gnt_cnt0=gnt_cnt1=2.
REQ-029 Scenario: port 1 op=6, A=B=32'h10, with rsp1_ready=0 for 3 cycles -> rsp1_valid=1, res=0, zero=1 held stable; req1_ready=0 while held; port 0 still served.
REQ-030 Scenario: opcodes 15 with A=32'h80000000, B=32'h24, and 8 -> res=32'hF8000000 (shift 4), then res=0, zero=1.
REQ-031 Scenario: rstn pulsed low mid-cycle while rsp0_valid=1 -> rsp0_valid=0 immediately, counters=0, next grant follows RR_INIT priority.
REQ-032 Scenario: gnt_cnt0 preloaded by 65535 accepts, then one more accept -> gnt_cnt0=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Two-port request/response bundle around the shared ALU arbiter.
// Latency: n/a (wiring only).
// Backpressure: reqN_ready is the grant; rspN_ready drains the per-port response slot.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_res;
    logic        rsp0_zero;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_res;
    logic        rsp1_zero;
    logic [15:0] gnt_cnt0;
    logic [15:0] gnt_cnt1;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_res, rsp0_zero,
        input  rsp1_valid, rsp1_res, rsp1_zero,
        input  gnt_cnt0, gnt_cnt1
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_res, rsp0_zero,
        output rsp1_valid, rsp1_res, rsp1_zero,
        output gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two request ports, one registered response slot per port.
// Latency: 1 cycle from acceptance to rspN_valid.
// Backpressure: a port is granted only if its slot is empty or draining this cycle; a stalled slot never blocks the other port.
module alu_arbiter #(
    parameter logic RR_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          rstn,
    alu_arbiter_if.slave  bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t state_q [2];
    slot_state_t state_d [2];

    logic [1:0]  req_vld;
    logic [1:0]  rsp_rdy;
    logic [1:0]  elig;
    logic [1:0]  gnt;
    logic        prio_q;
    logic        prio_d;
    logic [31:0] res_q  [2];
    logic        zero_q [2];
    logic [15:0] cnt_q  [2];

    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_res;
    logic        alu_zero;

    assign req_vld = {bus.req1_valid, bus.req0_valid};
    assign rsp_rdy = {bus.rsp1_ready, bus.rsp0_ready};

    // prio_q names the port that wins when both are eligible.
    always_comb begin
        elig = 2'b00;
        gnt  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            elig[i] = req_vld[i] & ((state_q[i] == EMPTY) | rsp_rdy[i]);
        end
        if (rstn) begin
            if (elig == 2'b11) begin
                gnt = prio_q ? 2'b10 : 2'b01;
            end else begin
                gnt = elig;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (gnt[0]) begin
            prio_d = 1'b1;
        end else if (gnt[1]) begin
            prio_d = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            if (gnt[i]) begin
                state_d[i] = FULL;
            end else if ((state_q[i] == FULL) && rsp_rdy[i]) begin
                state_d[i] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio_q <= RR_INIT;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= EMPTY;
            end
        end else begin
            prio_q <= prio_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    // The single shared ALU, fed from whichever port holds the grant.
    assign alu_op = gnt[1] ? bus.req1_op : bus.req0_op;
    assign alu_a  = gnt[1] ? bus.req1_a  : bus.req0_a;
    assign alu_b  = gnt[1] ? bus.req1_b  : bus.req0_b;

    always_comb begin
        alu_res = '0;
        case (alu_op)
            4'd0:    alu_res = alu_a & alu_b;
            4'd1:    alu_res = alu_a | alu_b;
            4'd2:    alu_res = alu_a + alu_b;
            4'd3:    alu_res = alu_a ^ alu_b;
            4'd4:    alu_res = ~(alu_a | alu_b);
            4'd5:    alu_res = alu_a >> alu_b[3:0];
            4'd6:    alu_res = alu_a - alu_b;
            4'd7:    alu_res = {31'd0, alu_a < alu_b};
            4'd9:    alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
            4'd14:   alu_res = alu_a << alu_b[3:0];
            4'd15:   alu_res = $signed(alu_a) >>> alu_b[3:0];
            default: alu_res = '0;
        endcase
    end

    assign alu_zero = (alu_res == '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 2; i++) begin
                res_q[i]  <= '0;
                zero_q[i] <= 1'b0;
                cnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    res_q[i]  <= alu_res;
                    zero_q[i] <= alu_zero;
                    cnt_q[i]  <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.rsp0_valid = (state_q[0] == FULL);
    assign bus.rsp1_valid = (state_q[1] == FULL);
    assign bus.rsp0_res   = res_q[0];
    assign bus.rsp1_res   = res_q[1];
    assign bus.rsp0_zero  = zero_q[0];
    assign bus.rsp1_zero  = zero_q[1];
    assign bus.gnt_cnt0   = cnt_q[0];
    assign bus.gnt_cnt1   = cnt_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a predictor queues expected responses, a monitor pops and compares them.
module tb_alu_arbiter;
    localparam logic RR_INIT_TB = 1'b0;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    alu_arbiter_if bus();

    alu_arbiter #(.RR_INIT(RR_INIT_TB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        zero;
    } exp_t;

    exp_t        q0 [$];
    exp_t        q1 [$];
    bit          m_full [2];
    logic        m_prio;
    logic [15:0] m_cnt [2];
    bit          gnt_m [2];

    bit          p_e0, p_e1, cur_v;
    int          p_w;
    exp_t        p_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain integer arithmetic.
    function automatic exp_t ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint p;
        longint sa;
        p = longint'(64'd1 << b[3:0]);
        case (op)
            4'd0:  e.res = a & b;
            4'd1:  e.res = a | b;
            4'd2:  e.res = 32'(longint'(a) + longint'(b));
            4'd3:  e.res = a ^ b;
            4'd4:  e.res = ~(a | b);
            4'd5:  e.res = 32'(longint'(a) / p);
            4'd6:  e.res = 32'(longint'(a) - longint'(b));
            4'd7:  e.res = (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
            4'd9:  e.res = (longint'($signed(a)) < longint'($signed(b))) ? 32'd1 : 32'd0;
            4'd14: e.res = 32'(longint'(a) * p);
            4'd15: begin
                sa = longint'($signed(a));
                if (sa < 0) sa = sa - (p - 1);
                e.res = 32'(sa / p);
            end
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    // Predictor: decides the expected grant from the driven inputs and the model's own slot/priority state.
    initial forever begin
        @(negedge clk or negedge rstn);
        if (!rstn) begin
            m_prio = RR_INIT_TB;
            for (int i = 0; i < 2; i++) begin
                m_full[i] = 1'b0;
                m_cnt[i]  = 16'd0;
                gnt_m[i]  = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            p_e0 = bus.req0_valid && (!m_full[0] || bus.rsp0_ready);
            p_e1 = bus.req1_valid && (!m_full[1] || bus.rsp1_ready);
            if (p_e0 && p_e1) p_w = m_prio ? 1 : 0;
            else if (p_e0)    p_w = 0;
            else if (p_e1)    p_w = 1;
            else              p_w = -1;
            chk1("req0_ready", bus.req0_ready, p_w == 0);
            chk1("req1_ready", bus.req1_ready, p_w == 1);
            chk("gnt_cnt0", 32'(bus.gnt_cnt0), 32'(m_cnt[0]));
            chk("gnt_cnt1", 32'(bus.gnt_cnt1), 32'(m_cnt[1]));
            gnt_m[0]  = (p_w == 0);
            gnt_m[1]  = (p_w == 1);
            m_full[0] = (p_w == 0) || (m_full[0] && !bus.rsp0_ready);
            m_full[1] = (p_w == 1) || (m_full[1] && !bus.rsp1_ready);
            if (p_w == 0) begin
                m_cnt[0]++;
                m_prio = 1'b1;
                p_exp  = ref_alu(bus.req0_op, bus.req0_a, bus.req0_b);
                #1 q0.push_back(p_exp);
            end else if (p_w == 1) begin
                m_cnt[1]++;
                m_prio = 1'b0;
                p_exp  = ref_alu(bus.req1_op, bus.req1_a, bus.req1_b);
                #1 q1.push_back(p_exp);
            end
        end
    end

    // Monitor: whatever the DUT presents must match the head of that port's queue.
    initial forever begin
        @(negedge clk);
        if (rstn) begin
            chk1("rsp0_valid", bus.rsp0_valid, q0.size() != 0);
            if (q0.size() != 0 && bus.rsp0_valid) begin
                chk("rsp0_res", bus.rsp0_res, q0[0].res);
                chk1("rsp0_zero", bus.rsp0_zero, q0[0].zero);
                if (bus.rsp0_ready) void'(q0.pop_front());
            end
            chk1("rsp1_valid", bus.rsp1_valid, q1.size() != 0);
            if (q1.size() != 0 && bus.rsp1_valid) begin
                chk("rsp1_res", bus.rsp1_res, q1[0].res);
                chk1("rsp1_zero", bus.rsp1_zero, q1[0].zero);
                if (bus.rsp1_ready) void'(q1.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1);
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (i == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'b1, 4'($urandom_range(0, 15)), $urandom, $urandom);
    endtask

    initial begin
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b0;
        bus.rsp1_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Reset state, with a request offered that must not be granted.
        rand_req(0);
        bus.rsp0_ready = 1'b1;
        @(negedge clk);
        chk1("rst_req0_ready", bus.req0_ready, 1'b0);
        chk1("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk1("rst_rsp1_valid", bus.rsp1_valid, 1'b0);
        chk("rst_rsp0_res", bus.rsp0_res, 32'd0);
        chk("rst_gnt_cnt0", 32'(bus.gnt_cnt0), 32'd0);
        @(posedge clk);
        #1;
        bus.req0_valid = 1'b0;
        rstn = 1'b1;

        // Both ports valid every cycle: grants alternate starting at port 0.
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        rand_req(0);
        rand_req(1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("alt_req0_ready", bus.req0_ready, (k % 2) == 0);
            chk1("alt_req1_ready", bus.req1_ready, (k % 2) == 1);
            nxt();
            if (gnt_m[0]) rand_req(0);
            if (gnt_m[1]) rand_req(1);
        end
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("alt_gnt_cnt0", 32'(bus.gnt_cnt0), 32'd2);
        chk("alt_gnt_cnt1", 32'(bus.gnt_cnt1), 32'd2);
        nxt();

        // Single ADD on port 0.
        set_req(0, 1'b1, 4'd2, 32'd5, 32'd7);
        @(negedge clk);
        chk1("add_req0_ready", bus.req0_ready, 1'b1);
        nxt();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk1("add_rsp0_valid", bus.rsp0_valid, 1'b1);
        chk("add_rsp0_res", bus.rsp0_res, 32'd12);
        chk1("add_rsp0_zero", bus.rsp0_zero, 1'b0);
        chk("add_gnt_cnt0", 32'(bus.gnt_cnt0), 32'd3);
        nxt();

        // Port 1 stalled holding a zero result while port 0 keeps flowing.
        bus.rsp1_ready = 1'b0;
        set_req(1, 1'b1, 4'd6, 32'h10, 32'h10);
        nxt();
        set_req(1, 1'b1, 4'd2, 32'd1, 32'd1);
        rand_req(0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk1("hold_rsp1_valid", bus.rsp1_valid, 1'b1);
            chk("hold_rsp1_res", bus.rsp1_res, 32'd0);
            chk1("hold_rsp1_zero", bus.rsp1_zero, 1'b1);
            chk1("hold_req1_ready", bus.req1_ready, 1'b0);
            chk1("hold_req0_ready", bus.req0_ready, 1'b1);
            nxt();
            rand_req(0);
        end
        bus.rsp1_ready = 1'b1;
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        nxt();
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);

        // Arithmetic shift right by B[3:0], then an unmapped opcode.
        set_req(0, 1'b1, 4'd15, 32'h8000_0000, 32'h24);
        nxt();
        set_req(0, 1'b1, 4'd8, 32'h1234, 32'h5);
        @(negedge clk);
        chk("sra_rsp0_res", bus.rsp0_res, 32'hF800_0000);
        chk1("sra_rsp0_zero", bus.rsp0_zero, 1'b0);
        nxt();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk("op8_rsp0_res", bus.rsp0_res, 32'd0);
        chk1("op8_rsp0_zero", bus.rsp0_zero, 1'b1);
        nxt();

        // Mid-cycle reset with a pending response.
        bus.rsp0_ready = 1'b0;
        set_req(0, 1'b1, 4'd1, 32'hF0, 32'h0F);
        nxt();
        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        chk1("pre_rst_rsp0_valid", bus.rsp0_valid, 1'b1);
        #2;
        rand_req(0);
        bus.rsp0_ready = 1'b1;
        #1;
        chk1("pre_rst_req0_ready", bus.req0_ready, 1'b1);
        rstn = 1'b0;
        #1;
        chk1("mid_rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        chk("mid_rst_rsp0_res", bus.rsp0_res, 32'd0);
        chk("mid_rst_gnt_cnt0", 32'(bus.gnt_cnt0), 32'd0);
        chk("mid_rst_gnt_cnt1", 32'(bus.gnt_cnt1), 32'd0);
        chk1("mid_rst_req0_ready", bus.req0_ready, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rand_req(1);
        @(negedge clk);
        chk1("post_rst_req0_ready", bus.req0_ready, RR_INIT_TB == 1'b0);
        chk1("post_rst_req1_ready", bus.req1_ready, RR_INIT_TB == 1'b1);
        nxt();

        // Counter wrap on port 0.
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rand_req(0);
        for (int k = 0; k < 65536; k++) begin
            nxt();
            rand_req(0);
            if (k == 65534) chk("wrap_cnt_ffff", 32'(bus.gnt_cnt0), 32'h0000_FFFF);
        end
        chk("wrap_cnt_zero", 32'(bus.gnt_cnt0), 32'd0);

        // Random traffic with random response backpressure.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 2; i++) begin
                cur_v = (i == 0) ? bus.req0_valid : bus.req1_valid;
                if (!cur_v || gnt_m[i]) begin
                    if ($urandom_range(0, 3) != 0) rand_req(i);
                    else set_req(i, 1'b0, 4'd0, 32'd0, 32'd0);
                end
            end
            bus.rsp0_ready = ($urandom_range(0, 3) != 0);
            bus.rsp1_ready = ($urandom_range(0, 3) != 0);
            nxt();
        end

        set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        repeat (4) nxt();
        chk("drain_q0", 32'(q0.size()), 32'd0);
        chk("drain_q1", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
